ahb_dw64_to_w32_bridge: RTL and testbench

- AHB-Lite 64-bit-to-32-bit downsizing bridge, sitting directly downstream of the SoC's shared 64-bit AHB master port (output of the IFU/LSU master mux).
- Acts as a 64-bit slave and drives a 32-bit AHB-Lite master bus toward memories and peripherals.
- Passes byte, half-word and word transfers through as single transfers.
- Splits each doubleword transfer into two 32-bit beats (low word, then high word) and reassembles read data.

---
 rtl/ahb_dw64_to_w32_bridge.sv | 174 +++++++++++++++++
 tb/tb_ahb_dw64_to_w32_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dw64_to_w32_bridge.sv
// ---------------------------------------------------------------------------
// ahb_dw64_to_w32_bridge
//
// AHB-Lite downsizing bridge. It is a 64-bit slave on the shared upstream
// master port and a 32-bit AHB-Lite master toward memories and peripherals.
// Byte, half-word and word transfers pass through as one downstream transfer.
// Each doubleword becomes two word beats (low word, then high word). The read
// data from the two beats is put back together into one 64-bit word.
//
// Ports
//   HCLK, HRESETn    clock; synchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   upstream 64-bit slave request side
//   HRDATA, HREADYOUT                  upstream 64-bit slave response side
//   M_HADDR/M_HTRANS/M_HWRITE/M_HSIZE/M_HWDATA  downstream 32-bit master
//   M_HRDATA, M_HREADY                          downstream response
//
// HWDATA is not registered. The upstream master keeps it stable for the whole
// upstream data phase (ADDR1 through DATA2), so each half is routed
// combinationally into the matching downstream data phase.
// ---------------------------------------------------------------------------
module ahb_dw64_to_w32_bridge #(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [63:0]   HWDATA,
    output logic [63:0]   HRDATA,
    output logic          HREADYOUT,
    output logic [AW-1:0] M_HADDR,
    output logic [1:0]    M_HTRANS,
    output logic          M_HWRITE,
    output logic [2:0]    M_HSIZE,
    output logic [31:0]   M_HWDATA,
    input  logic [31:0]   M_HRDATA,
    input  logic          M_HREADY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR1 = 2'd1,
        S_DATA1 = 2'd2,
        S_DATA2 = 2'd3
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic          dbl_q;
    logic [31:0]   lo_q;

    logic          accept;
    logic          htrans_unused;

    // Sizes of 3 and above are all treated as doubleword.
    function automatic logic is_dbl(input logic [2:0] size);
        return (size >= 3'd3);
    endfunction

    // Address of the low (hi=0) or high (hi=1) word of the aligned 8-byte pair.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic hi);
        return {a[AW-1:3], hi, 2'b00};
    endfunction

    // HTRANS[0] only tells SEQ from NONSEQ and IDLE from BUSY. The bridge
    // treats both members of each pair the same way.
    assign htrans_unused = HTRANS[0];

    // Upstream ready: this is high in IDLE, and in the cycle where the last
    // downstream data phase of the current transfer completes.
    always_comb begin
        HREADYOUT = 1'b0;
        case (state)
            S_IDLE:  HREADYOUT = 1'b1;
            S_ADDR1: HREADYOUT = 1'b0;
            S_DATA1: HREADYOUT = !dbl_q && M_HREADY;
            S_DATA2: HREADYOUT = M_HREADY;
            default: HREADYOUT = 1'b0;
        endcase
    end

    assign accept = HREADYOUT && HTRANS[1];

    // Upstream read data. A single transfer replicates the word onto both
    // lanes. A doubleword joins the stored low beat with the live high beat.
    always_comb begin
        HRDATA = '0;
        case (state)
            S_DATA1: HRDATA = dbl_q ? 64'd0 : {M_HRDATA, M_HRDATA};
            S_DATA2: HRDATA = {M_HRDATA, lo_q};
            default: HRDATA = '0;
        endcase
    end

    // Downstream write data: pick the lane for the word being transferred.
    always_comb begin
        M_HWDATA = '0;
        case (state)
            S_DATA1: M_HWDATA = (dbl_q || !addr_q[2]) ? HWDATA[31:0] : HWDATA[63:32];
            S_DATA2: M_HWDATA = HWDATA[63:32];
            default: M_HWDATA = '0;
        endcase
    end

    // Downstream address phase. All of these outputs depend only on registers.
    // ADDR1 carries the first beat. DATA1 of a doubleword carries the SEQ
    // second beat. All other states show IDLE and leave the last address
    // and control in place.
    always_comb begin
        M_HTRANS = TR_IDLE;
        case (state)
            S_ADDR1: M_HTRANS = TR_NONSEQ;
            S_DATA1: M_HTRANS = dbl_q ? TR_SEQ : TR_IDLE;
            default: M_HTRANS = TR_IDLE;
        endcase
    end

    assign M_HADDR  = dbl_q ? beat_addr(addr_q, state != S_ADDR1) : addr_q;
    assign M_HSIZE  = dbl_q ? 3'd2 : size_q;
    assign M_HWRITE = write_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            dbl_q   <= 1'b0;
            lo_q    <= '0;
        end else if (accept) begin
            // A new transfer can be accepted in IDLE. It can also be accepted
            // in the cycle that completes the previous transfer, so there is
            // no idle cycle between back-to-back transfers.
            state   <= S_ADDR1;
            addr_q  <= HADDR;
            size_q  <= is_dbl(HSIZE) ? 3'd3 : HSIZE;
            write_q <= HWRITE;
            dbl_q   <= is_dbl(HSIZE);
        end else begin
            case (state)
                S_ADDR1: begin
                    if (M_HREADY) begin
                        state <= S_DATA1;
                    end
                end
                S_DATA1: begin
                    if (M_HREADY) begin
                        if (dbl_q) begin
                            state <= S_DATA2;
                            lo_q  <= M_HRDATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA2: begin
                    if (M_HREADY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dw64_to_w32_bridge.sv
module tb_ahb_dw64_to_w32_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;

    ahb_dw64_to_w32_bridge #(.AW(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .M_HADDR   (M_HADDR),
        .M_HTRANS  (M_HTRANS),
        .M_HWRITE  (M_HWRITE),
        .M_HSIZE   (M_HSIZE),
        .M_HWDATA  (M_HWDATA),
        .M_HRDATA  (M_HRDATA),
        .M_HREADY  (M_HREADY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [63:0] wdata;
        int          w1;
        int          w2;
        int          gap;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [1:0]  trans;
        logic [31:0] wdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic        write;
        logic [63:0] rdata;
        int          lat;
    } up_t;

    req_t  reqq[$];
    beat_t beatq[$];
    up_t   upq[$];

    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endfunction

    // Downstream memory: preloaded words, otherwise a fixed hash of the word address.
    function automatic logic [31:0] rd_word(logic [31:0] a);
        logic [31:0] w;
        w = a - (a % 4);
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Reference model: what a 64-bit request must turn into on the 32-bit bus.
    function automatic void push_expect(req_t r);
        beat_t       b;
        up_t         u;
        logic [31:0] base;
        base    = r.addr - (r.addr % 8);
        b.write = r.write;
        u.write = r.write;
        if (r.size >= 3) begin
            b.addr = base;     b.size = 3'd2; b.trans = 2'b10;
            b.wdata = r.wdata[31:0];  b.waits = r.w1;
            beatq.push_back(b);
            b.addr = base + 4; b.size = 3'd2; b.trans = 2'b11;
            b.wdata = r.wdata[63:32]; b.waits = r.w2;
            beatq.push_back(b);
            u.rdata = {rd_word(base + 4), rd_word(base)};
            u.lat   = 2 + r.w1 + r.w2;
        end else begin
            b.addr  = r.addr; b.size = r.size; b.trans = 2'b10;
            b.wdata = ((r.addr / 4) % 2 == 1) ? r.wdata[63:32] : r.wdata[31:0];
            b.waits = r.w1;
            beatq.push_back(b);
            u.rdata = {rd_word(r.addr), rd_word(r.addr)};
            u.lat   = 1 + r.w1;
        end
        upq.push_back(u);
    endfunction

    task automatic add_req(logic [31:0] addr, logic [2:0] size, logic write,
                           logic [63:0] wdata, int w1, int w2, int gap);
        req_t r;
        r.addr = addr; r.size = size; r.write = write; r.wdata = wdata;
        r.w1 = w1; r.w2 = w2; r.gap = gap;
        reqq.push_back(r);
    endtask

    // ---------------- upstream master driver (pipelined AHB) ----------------
    bit   have_addr = 0;
    bit   dph_act   = 0;
    bit   drive_act = 0;
    int   idle_left = 0;
    req_t cur;
    req_t dph;

    initial begin
        HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HWDATA = '0;
        forever begin
            @(posedge HCLK); #1;
            if (!have_addr && reqq.size() > 0) begin
                cur       = reqq.pop_front();
                have_addr = 1;
                idle_left = cur.gap;
            end
            drive_act = have_addr && (idle_left == 0);
            if (have_addr && idle_left > 0) idle_left--;
            if (drive_act) begin
                HADDR  = cur.addr;
                HSIZE  = cur.size;
                HWRITE = cur.write;
                HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            end else begin
                HADDR  = $urandom;
                HSIZE  = 3'($urandom_range(0, 7));
                HWRITE = 1'($urandom_range(0, 1));
                HTRANS = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            end
            HWDATA = dph_act ? dph.wdata : {$urandom, $urandom};
            @(negedge HCLK);
            if (!HRESETn) begin
                have_addr = 0;
                dph_act   = 0;
            end else if (HREADYOUT) begin
                dph_act = drive_act;
                if (drive_act) begin
                    dph       = cur;
                    have_addr = 0;
                    push_expect(cur);
                end
            end
        end
    end

    // ---------------- upstream monitor ----------------
    bit up_pend = 0;
    int up_lat  = 0;

    always @(negedge HCLK) begin
        up_t e;
        if (!HRESETn) begin
            up_pend = 0;
            upq.delete();
        end else begin
            if (up_pend) begin
                if (HREADYOUT) begin
                    if (upq.size() == 0) begin
                        fail_now("up_unexpected_completion");
                    end else begin
                        e = upq.pop_front();
                        chk("up_latency", 64'(up_lat), 64'(e.lat));
                        if (!e.write) chk("up_hrdata", HRDATA, e.rdata);
                    end
                    up_pend = 0;
                end else begin
                    up_lat++;
                end
            end
            if (HREADYOUT && HTRANS[1]) begin
                up_pend = 1;
                up_lat  = 0;
            end
        end
    end

    // ---------------- downstream slave + monitor ----------------
    bit          dp_act     = 0;
    int          dp_left    = 0;
    beat_t       dp;
    logic [31:0] dp_addr;
    bit          stall_prev = 0;
    logic [31:0] st_addr;
    logic [1:0]  st_trans;
    logic [2:0]  st_size;
    logic        n_hready   = 1'b1;
    logic [31:0] n_hrdata   = '0;

    initial begin
        M_HREADY = 1'b1;
        M_HRDATA = '0;
    end

    always @(negedge HCLK) begin
        beat_t b;
        if (!HRESETn) begin
            dp_act     = 0;
            stall_prev = 0;
            beatq.delete();
            n_hready   = 1'b1;
            n_hrdata   = '0;
        end else begin
            if (stall_prev) begin
                chk("dn_hold_addr",  64'(M_HADDR),  64'(st_addr));
                chk("dn_hold_trans", 64'(M_HTRANS), 64'(st_trans));
                chk("dn_hold_size",  64'(M_HSIZE),  64'(st_size));
            end
            stall_prev = M_HTRANS[1] && !M_HREADY;
            st_addr = M_HADDR; st_trans = M_HTRANS; st_size = M_HSIZE;
            if (dp_act && M_HREADY) begin
                if (dp.write) chk("dn_hwdata", 64'(M_HWDATA), 64'(dp.wdata));
                dp_act = 0;
            end
            if (M_HTRANS[1] && M_HREADY) begin
                if (beatq.size() == 0) begin
                    $display("FAIL dn_unexpected_beat: got trans=%b addr=%h expected none",
                             M_HTRANS, M_HADDR);
                    total++;
                    bad++;
                end else begin
                    b = beatq.pop_front();
                    chk("dn_haddr",  64'(M_HADDR),  64'(b.addr));
                    chk("dn_hsize",  64'(M_HSIZE),  64'(b.size));
                    chk("dn_hwrite", 64'(M_HWRITE), 64'(b.write));
                    chk("dn_htrans", 64'(M_HTRANS), 64'(b.trans));
                    dp      = b;
                    dp_act  = 1;
                    dp_left = b.waits;
                    dp_addr = M_HADDR;
                end
            end
            if (dp_act && dp_left > 0) begin
                n_hready = 1'b0;
                n_hrdata = $urandom;
                dp_left--;
            end else if (dp_act) begin
                n_hready = 1'b1;
                n_hrdata = rd_word(dp_addr);
            end else begin
                n_hready = 1'b1;
                n_hrdata = $urandom;
            end
        end
    end

    always @(posedge HCLK) begin
        #1;
        M_HREADY = n_hready;
        M_HRDATA = n_hrdata;
    end

    // ---------------- main sequence ----------------
    task automatic drain(string name);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge HCLK);
            done = (reqq.size() == 0) && !have_addr && !dph_act && !up_pend &&
                   (upq.size() == 0) && (beatq.size() == 0);
        end
        if (!done) fail_now(name);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_hreadyout"}, 64'(HREADYOUT), 64'd1);
        chk({tag, "_m_htrans"},  64'(M_HTRANS),  64'd0);
        chk({tag, "_m_haddr"},   64'(M_HADDR),   64'd0);
        chk({tag, "_hrdata"},    HRDATA,         64'd0);
        chk({tag, "_m_hwdata"},  64'(M_HWDATA),  64'd0);
    endtask

    initial begin
        bit          seen;
        int          sz;
        logic [31:0] a;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check_reset_state("reset");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Directed transfers.
        mem[32'h2000_0004] = 32'hDEADBEEF;
        add_req(32'h2000_0004, 3'd2, 1'b0, 64'd0, 0, 0, 1);
        add_req(32'h2000_0010, 3'd3, 1'b1, 64'h11223344_55667788, 0, 0, 2);
        add_req(32'h0000_0008, 3'd3, 1'b0, 64'd0, 2, 0, 2);
        add_req(32'h0000_0003, 3'd0, 1'b1, 64'h12345678_000000AA, 0, 0, 2);
        add_req(32'h0000_0004, 3'd2, 1'b0, 64'd0, 0, 0, 0);
        add_req(32'h0000_0105, 3'd7, 1'b1, 64'hCAFEF00D_0BADBEEF, 1, 1, 0);
        add_req(32'h0000_0106, 3'd1, 1'b1, 64'hAAAA5555_BBBB6666, 0, 2, 0);
        drain("drain_directed");

        // Randomized transfers.
        for (int i = 0; i < 80; i++) begin
            sz = $urandom_range(0, 7);
            a  = $urandom;
            if (sz < 3) a = a - (a % (1 << sz));
            add_req(a, 3'(sz), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        drain("drain_random");

        // Reset while a doubleword is waiting in its first data phase.
        add_req(32'h0000_0040, 3'd3, 1'b1, 64'h99887766_55443322, 3, 0, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge HCLK);
            seen = (M_HTRANS == 2'b11);
        end
        if (!seen) fail_now("midreset_no_seq_phase");
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check_reset_state("midreset");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (8) @(negedge HCLK);

        // Normal traffic after the mid-transfer reset.
        add_req(32'h0000_0050, 3'd2, 1'b1, 64'h0F0E0D0C_0B0A0908, 0, 0, 0);
        add_req(32'h0000_0058, 3'd3, 1'b0, 64'd0, 0, 1, 0);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
